// File: rtl/la_ioring_cfg.sv
// Serial configuration master for the IO ring: a per-pad config bank that is
// shifted out MSB-first (last pad first) on sdata/sclk, then latched with supdate.

module la_ioring_cfg_pad #(
    parameter int               CFGW        = 8,
    parameter logic [CFGW-1:0]  CFG_DEFAULT = '0
) (
    input  logic            clk,
    input  logic            nreset,
    input  logic            we,
    input  logic [CFGW-1:0] d,
    output logic [CFGW-1:0] q
);
    always_ff @(posedge clk) begin
        if (!nreset)  q <= CFG_DEFAULT;
        else if (we)  q <= d;
    end
endmodule

module la_ioring_cfg #(
    parameter int               NPADS       = 16,
    parameter int               CFGW        = 8,
    parameter int               RINGW       = 8,
    parameter logic [CFGW-1:0]  CFG_DEFAULT = '0,
    localparam int              AW          = (NPADS > 1) ? $clog2(NPADS) : 1
) (
    input  logic             clk,
    input  logic             nreset,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [CFGW-1:0]  wr_data,
    output logic             wr_err,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [RINGW-1:0] ioring
);
    localparam int N  = NPADS * CFGW;
    localparam int CW = $clog2(N + 1);
    localparam logic [N-1:0] MSB1 = N'(1) << (N - 1);

    typedef enum logic [1:0] {IDLE, SHIFT_LO, SHIFT_HI, UPDATE} state_t;

    state_t                       state, state_nxt;
    logic [CW-1:0]                cnt, cnt_nxt;
    logic [NPADS-1:0][CFGW-1:0]   bank, bank_nxt;
    logic [NPADS-1:0]             we;
    logic                         wr_ok, wr_bad;
    logic [N-1:0]                 flat_nxt, sel;
    logic                         sdata, sclk, supd;
    logic                         sdata_d, sclk_d, supd_d, busy_d, done_d;

    assign wr_ok  = wr_en && (state == IDLE) && (int'(wr_addr) < NPADS);
    assign wr_bad = wr_en && !wr_ok;

    // bank_nxt lets a write issued together with start land in the first bit
    for (genvar i = 0; i < NPADS; i++) begin : g_pad
        assign we[i]       = wr_ok && (wr_addr == AW'(i));
        assign bank_nxt[i] = we[i] ? wr_data : bank[i];

        la_ioring_cfg_pad #(.CFGW(CFGW), .CFG_DEFAULT(CFG_DEFAULT)) u_pad (
            .clk    (clk),
            .nreset (nreset),
            .we     (we[i]),
            .d      (wr_data),
            .q      (bank[i])
        );
    end

    assign flat_nxt = bank_nxt;
    assign sel      = MSB1 >> cnt_nxt;

    always_ff @(posedge clk) begin
        if (!nreset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: if (start) begin
                state_nxt = SHIFT_LO;
                cnt_nxt   = '0;
            end
            SHIFT_LO: state_nxt = SHIFT_HI;
            SHIFT_HI: begin
                if (cnt == CW'(N - 1)) begin
                    state_nxt = UPDATE;
                end else begin
                    state_nxt = SHIFT_LO;
                    cnt_nxt   = cnt + CW'(1);
                end
            end
            UPDATE:   state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // Outputs are decoded from the next state and registered
    always_comb begin
        busy_d  = (state_nxt != IDLE);
        sclk_d  = (state_nxt == SHIFT_HI);
        supd_d  = (state_nxt == UPDATE);
        done_d  = (state == UPDATE);
        sdata_d = 1'b0;
        if (state_nxt == SHIFT_LO || state_nxt == SHIFT_HI)
            sdata_d = |(flat_nxt & sel);
    end

    always_ff @(posedge clk) begin
        if (!nreset) begin
            sdata  <= 1'b0;
            sclk   <= 1'b0;
            supd   <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            wr_err <= 1'b0;
        end else begin
            sdata  <= sdata_d;
            sclk   <= sclk_d;
            supd   <= supd_d;
            busy   <= busy_d;
            done   <= done_d;
            wr_err <= wr_bad;
        end
    end

    always_comb begin
        ioring    = '0;
        ioring[0] = sdata;
        ioring[1] = sclk;
        ioring[2] = supd;
    end
endmodule

// File: tb/tb_la_ioring_cfg.sv
// Randomized bench for la_ioring_cfg: a bank/stream model predicts every
// cycle of each shift sequence, including locked-out writes and resets.

module tb_la_ioring_cfg;
    localparam int NPADS = 3;
    localparam int CFGW  = 4;
    localparam int RINGW = 8;
    localparam int AW    = $clog2(NPADS);
    localparam int N     = NPADS * CFGW;
    localparam int T     = 2 * N + 2;
    localparam logic [CFGW-1:0] DEF = 4'h5;

    logic             clk = 1'b0;
    logic             nreset, wr_en, start;
    logic [AW-1:0]    wr_addr;
    logic [CFGW-1:0]  wr_data;
    logic             wr_err, busy, done;
    logic [RINGW-1:0] ioring;

    int               nchk = 0, npass = 0;
    logic [CFGW-1:0]  model [NPADS];
    bit               stream [$];

    la_ioring_cfg #(.NPADS(NPADS), .CFGW(CFGW), .RINGW(RINGW), .CFG_DEFAULT(DEF)) dut (
        .clk     (clk),
        .nreset  (nreset),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .wr_err  (wr_err),
        .start   (start),
        .busy    (busy),
        .done    (done),
        .ioring  (ioring)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        else             npass++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int p = 0; p < NPADS; p++) model[p] = DEF;
    endtask

    // Wire order: highest pad first, each word MSB first
    task automatic build_stream();
        stream.delete();
        for (int p = NPADS - 1; p >= 0; p--)
            for (int b = CFGW - 1; b >= 0; b--)
                stream.push_back(model[p][b]);
    endtask

    function automatic logic [RINGW-1:0] expring(input int c);
        logic [RINGW-1:0] r;
        r = '0;
        if (c >= 1 && c <= 2 * N) begin
            r[0] = stream[(c - 1) / 2];
            r[1] = (c % 2 == 0);
        end else if (c == 2 * N + 1) begin
            r[2] = 1'b1;
        end
        return r;
    endfunction

    task automatic wr(input int a, input logic [CFGW-1:0] d);
        wr_en   = 1'b1;
        wr_addr = AW'(a);
        wr_data = d;
        step();
        wr_en = 1'b0;
        chk($sformatf("wr_err a%0d", a), wr_err, a >= NPADS);
        chk("idle busy", busy, 0);
        if (a < NPADS) model[a] = d;
        step();
        chk("wr_err clr", wr_err, 0);
    endtask

    // wr_cyc/rst_cyc: cycle (1..) at which to write/reset, 0 for none
    task automatic seq(input int wr_cyc, input int rst_cyc, input bit b2b,
                       input bit wstart, input bit pre);
        if (!pre) begin
            start = 1'b1;
            if (wstart) begin
                wr_en   = 1'b1;
                wr_addr = AW'($urandom_range(NPADS - 1));
                wr_data = CFGW'($urandom);
                model[wr_addr] = wr_data;
            end
            step();
            start = 1'b0;
            wr_en = 1'b0;
        end
        build_stream();
        for (int c = 1; c <= T; c++) begin
            chk($sformatf("busy c%0d", c), busy, c <= 2 * N + 1);
            chk($sformatf("done c%0d", c), done, c == T);
            chk($sformatf("ioring c%0d", c), ioring, expring(c));
            chk($sformatf("wr_err c%0d", c), wr_err, wr_cyc != 0 && c == wr_cyc + 1);
            if (c == wr_cyc) begin
                wr_en   = 1'b1;
                wr_addr = AW'($urandom_range(NPADS - 1));
                wr_data = ~model[wr_addr];
            end
            if (c == rst_cyc) nreset = 1'b0;
            if (c == T && b2b) start = 1'b1;
            if (c != T || !b2b) start = start & (c == T) & b2b;
            step();
            wr_en = 1'b0;
            start = 1'b0;
            if (c == rst_cyc) begin
                nreset = 1'b1;
                model_reset();
                chk("rst busy", busy, 0);
                for (int k = 0; k < T; k++) begin
                    chk($sformatf("rst ioring k%0d", k), ioring, 0);
                    chk($sformatf("rst done k%0d", k), done, 0);
                    step();
                end
                return;
            end
        end
    endtask

    initial begin
        nreset  = 1'b0;
        wr_en   = 1'b0;
        start   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        model_reset();

        for (int i = 0; i < 3; i++) begin
            wr_en   = 1'($urandom);
            start   = 1'($urandom);
            wr_addr = AW'($urandom);
            wr_data = CFGW'($urandom);
            step();
            chk("rst ioring", ioring, 0);
            chk("rst busy", busy, 0);
            chk("rst done", done, 0);
            chk("rst wr_err", wr_err, 0);
        end
        wr_en  = 1'b0;
        start  = 1'b0;
        nreset = 1'b1;
        step();
        seq(0, 0, 0, 0, 0);

        wr(0, 4'hA);
        wr(1, 4'h3);
        wr(2, CFGW'($urandom));
        seq(0, 0, 0, 0, 0);

        seq(5, 0, 0, 0, 0);

        wr(3, CFGW'($urandom));
        seq(0, 0, 0, 0, 0);

        wr(1, 4'hC);
        seq(0, 7, 0, 0, 0);
        seq(0, 0, 0, 0, 0);

        for (int r = 0; r < 4; r++) begin
            for (int w = 0; w < 3; w++) wr($urandom_range(NPADS), CFGW'($urandom));
            seq($urandom_range(2 * N + 1), 0, 0, 0, 0);
        end

        wr(2, 4'h9);
        seq(0, 0, 1, 0, 0);
        seq(0, 0, 0, 0, 1);

        seq(0, 0, 0, 1, 0);
        seq(0, 0, 0, 1, 0);

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end
endmodule
